// File: rtl/cache_pkg.sv
// Shared sizing helpers and entry layout for the set-associative cache.
// Used by the storage array and by the cache controller.
package cache_pkg;

    function automatic int way_bits(input int num_ways);
        return $clog2(num_ways);
    endfunction

    function automatic int set_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int offset_bits(input int block_size);
        return $clog2(block_size / 8);
    endfunction

    function automatic int tag_bits(
        input int addr_size,
        input int num_sets,
        input int block_size
    );
        return addr_size - set_bits(num_sets) - offset_bits(block_size);
    endfunction

    localparam int DefTagBits   = tag_bits(32, 4, 32);
    localparam int DefBlockBits = 32;

    typedef struct packed {
        logic                    valid;
        logic [DefTagBits-1:0]   tag;
        logic [DefBlockBits-1:0] data;
    } cache_entry_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: NUM_SETS entries of {valid, tag, data}.
// Synchronous fill port, combinational read and tag compare.
module cache_way #(
    parameter int NUM_SETS   = 4,
    parameter int SET_SIZE   = 2,
    parameter int TAG_SIZE   = 28,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_SIZE-1:0]   set,
    input  logic [TAG_SIZE-1:0]   tag,
    input  logic                  write_enable,
    input  logic [BLOCK_SIZE-1:0] write_data,
    output logic [BLOCK_SIZE-1:0] read_data,
    output logic                  hit,
    output logic                  valid
);

    logic                  r_valid [NUM_SETS];
    logic [TAG_SIZE-1:0]   r_tag   [NUM_SETS];
    logic [BLOCK_SIZE-1:0] r_data  [NUM_SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (write_enable) begin
            r_valid[set] <= 1'b1;
            r_tag[set]   <= tag;
            r_data[set]  <= write_data;
        end
    end

    // hit is the raw compare; valid qualifies it with the entry's valid bit
    assign read_data = r_data[set];
    assign hit       = (r_tag[set] == tag);
    assign valid     = r_valid[set] & hit;

endmodule

// File: rtl/cache_memory.sv
// Set-associative cache storage array: NUM_WAYS ways of cache_way,
// read_data muxed by way, per-way raw hits and valid-qualified hits.
module cache_memory
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int BLOCK_SIZE = 32,
    localparam int WaySize    = way_bits(NUM_WAYS),
    localparam int SetSize    = set_bits(NUM_SETS),
    localparam int OffsetSize = offset_bits(BLOCK_SIZE),
    localparam int TagSize    = ADDR_SIZE - SetSize - OffsetSize
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WaySize-1:0]    way,
    input  logic [SetSize-1:0]    set,
    input  logic [TagSize-1:0]    tag,
    input  logic                  write_enable,
    input  logic [BLOCK_SIZE-1:0] write_data,
    output logic [BLOCK_SIZE-1:0] read_data,
    output logic [NUM_WAYS-1:0]   hits,
    output logic [NUM_WAYS-1:0]   valid_flags
);

    logic [BLOCK_SIZE-1:0] w_rdata [NUM_WAYS];
    logic [NUM_WAYS-1:0]   w_we;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign w_we[w] = write_enable && (way == WaySize'(w));

        cache_way #(
            .NUM_SETS   (NUM_SETS),
            .SET_SIZE   (SetSize),
            .TAG_SIZE   (TagSize),
            .BLOCK_SIZE (BLOCK_SIZE)
        ) u_way (
            .clk          (clk),
            .rst          (rst),
            .set          (set),
            .tag          (tag),
            .write_enable (w_we[w]),
            .write_data   (write_data),
            .read_data    (w_rdata[w]),
            .hit          (hits[w]),
            .valid        (valid_flags[w])
        );
    end

    assign read_data = w_rdata[way];

endmodule

// File: tb/tb_cache_memory.sv
// Directed scoreboard bench for cache_memory: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_cache_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  way = '0;
    logic [1:0]  set = '0;
    logic [27:0] tag = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [1:0]  hits;
    logic [1:0]  valid_flags;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [1:0]  h;
        logic [1:0]  v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cache_memory dut (
        .clk          (clk),
        .rst          (rst),
        .way          (way),
        .set          (set),
        .tag          (tag),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .hits         (hits),
        .valid_flags  (valid_flags)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (read_data !== e.rd) begin
                n_bad++;
                $display("FAIL %s read_data: got %h want %h", e.name, read_data, e.rd);
            end
            n_cmp++;
            if (hits !== e.h) begin
                n_bad++;
                $display("FAIL %s hits: got %b want %b", e.name, hits, e.h);
            end
            n_cmp++;
            if (valid_flags !== e.v) begin
                n_bad++;
                $display("FAIL %s valid_flags: got %b want %b", e.name, valid_flags, e.v);
            end
        end
    end

    task automatic do_reset(input logic we);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        write_enable = we;
        way          = 1'b0;
        set          = 2'd1;
        tag          = 28'h9;
        write_data   = 32'h9999_9999;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic wr(input logic w, input logic [1:0] s,
                      input logic [27:0] t, input logic [31:0] d);
        @(posedge clk);
        #1;
        way          = w;
        set          = s;
        tag          = t;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic chk(input string name, input logic w, input logic [1:0] s,
                       input logic [27:0] t, input logic [31:0] rd,
                       input logic [1:0] h, input logic [1:0] v);
        exp_t e;
        way = w;
        set = s;
        tag = t;
        e.name = name;
        e.rd   = rd;
        e.h    = h;
        e.v    = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_tag0",      1'b0, 2'd0, 28'h0,       32'h0,         2'b11, 2'b00);
        chk("rst_set2",      1'b1, 2'd2, 28'h5,       32'h0,         2'b00, 2'b00);

        wr(1'b0, 2'd0, 28'h0ABCDEF, 32'hDEADBEEF);
        chk("fill_w0",       1'b0, 2'd0, 28'h0ABCDEF, 32'hDEADBEEF,  2'b01, 2'b01);
        chk("tag_miss",      1'b0, 2'd0, 28'h0ABCDF0, 32'hDEADBEEF,  2'b00, 2'b00);
        chk("tag_restore",   1'b0, 2'd0, 28'h0ABCDEF, 32'hDEADBEEF,  2'b01, 2'b01);

        wr(1'b1, 2'd0, 28'h0000123, 32'h12345678);
        chk("w0_kept",       1'b0, 2'd0, 28'h0ABCDEF, 32'hDEADBEEF,  2'b01, 2'b01);
        chk("w1_hit",        1'b1, 2'd0, 28'h0000123, 32'h12345678,  2'b10, 2'b10);
        chk("no_alias",      1'b0, 2'd1, 28'h0ABCDEF, 32'h0,         2'b00, 2'b00);
        chk("raw_zero_tag",  1'b0, 2'd1, 28'h0,       32'h0,         2'b11, 2'b00);

        wr(1'b1, 2'd3, 28'h0000007, 32'hCAFEF00D);
        chk("set3_w1",       1'b1, 2'd3, 28'h0000007, 32'hCAFEF00D,  2'b10, 2'b10);
        chk("set3_w0",       1'b0, 2'd3, 28'h0000007, 32'h0,         2'b10, 2'b10);

        wr(1'b0, 2'd2, 28'h0000055, 32'h0000_1111);
        wr(1'b1, 2'd2, 28'h0000055, 32'h0000_2222);
        chk("dup_w1",        1'b1, 2'd2, 28'h0000055, 32'h0000_2222, 2'b11, 2'b11);
        chk("dup_w0",        1'b0, 2'd2, 28'h0000055, 32'h0000_1111, 2'b11, 2'b11);

        do_reset(1'b1);
        chk("rst_drop_wr",   1'b0, 2'd1, 28'h9,       32'h0,         2'b00, 2'b00);
        chk("rst_clr_tag",   1'b0, 2'd0, 28'h0ABCDEF, 32'h0,         2'b00, 2'b00);
        chk("rst_clr_zero",  1'b1, 2'd0, 28'h0,       32'h0,         2'b11, 2'b00);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
